// File: rtl/hyper_result_stage.sv
// hyper_result_stage: serializes cosh/sinh/exp results as tagged beats
// onto one result bus, counting completed vectors.
package hyperCord_pkg;
  localparam int IDWIDTH = 16;
endpackage

module hyper_result_stage
  import hyperCord_pkg::*;
#(
  parameter int DWIDTH = IDWIDTH,
  parameter bit EXP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] Xin,
  input  logic [DWIDTH-1:0] Yin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        out_tag,
  output logic              out_last,
  output logic              sat_flag,
  output logic [15:0]       vec_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COSH = 2'd1,
    SINH = 2'd2,
    EXP  = 2'd3
  } state_t;

  localparam logic [DWIDTH-1:0] POS_MAX =
    {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] NEG_MAX =
    {1'b1, {(DWIDTH-1){1'b0}}};

  state_t            state;
  logic [DWIDTH-1:0] x_r;
  logic [DWIDTH-1:0] y_r;
  logic [DWIDTH-1:0] sum_r;
  logic              ovf_r;

  logic [DWIDTH:0]   sum;
  logic              ovf;
  logic [DWIDTH-1:0] sum_sat;

  // sign-extended add; top two bits disagreeing means overflow
  assign sum = {Xin[DWIDTH-1], Xin} + {Yin[DWIDTH-1], Yin};
  assign ovf = sum[DWIDTH] ^ sum[DWIDTH-1];

  always_comb begin
    sum_sat = sum[DWIDTH-1:0];
    if (ovf)
      sum_sat = sum[DWIDTH] ? NEG_MAX : POS_MAX;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state != IDLE);

  // outputs are loaded for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      sum_r     <= '0;
      ovf_r     <= 1'b0;
      out_data  <= '0;
      out_tag   <= 2'b00;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      vec_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_r      <= Xin;
            y_r      <= Yin;
            sum_r    <= sum_sat;
            ovf_r    <= ovf;
            state    <= COSH;
            out_data <= Xin;
            out_tag  <= 2'b00;
            out_last <= 1'b0;
            sat_flag <= 1'b0;
          end
        end
        COSH: begin
          if (out_ready) begin
            state    <= SINH;
            out_data <= y_r;
            out_tag  <= 2'b01;
            out_last <= !EXP_EN;
          end
        end
        SINH: begin
          if (out_ready) begin
            if (EXP_EN) begin
              state    <= EXP;
              out_data <= sum_r;
              out_tag  <= 2'b10;
              out_last <= 1'b1;
              sat_flag <= ovf_r;
            end else begin
              state     <= IDLE;
              out_data  <= '0;
              out_tag   <= 2'b00;
              out_last  <= 1'b0;
              vec_count <= vec_count + 16'd1;
            end
          end
        end
        EXP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_data  <= '0;
            out_tag   <= 2'b00;
            out_last  <= 1'b0;
            sat_flag  <= 1'b0;
            vec_count <= vec_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_result_stage.sv
// tb_hyper_result_stage: directed vectors for the result serializer,
// one instance with the exp beat and one without.
module tb_hyper_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [15:0] a_x = '0;
  logic [15:0] a_y = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [15:0] a_data;
  logic [1:0]  a_tag;
  logic        a_last;
  logic        a_sat;
  logic [15:0] a_cnt;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_x = '0;
  logic [15:0] b_y = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [15:0] b_data;
  logic [1:0]  b_tag;
  logic        b_last;
  logic        b_sat;
  logic [15:0] b_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hyper_result_stage #(.DWIDTH(16), .EXP_EN(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .Xin(a_x), .Yin(a_y),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_data), .out_tag(a_tag),
    .out_last(a_last), .sat_flag(a_sat),
    .vec_count(a_cnt)
  );

  hyper_result_stage #(.DWIDTH(16), .EXP_EN(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .Xin(b_x), .Yin(b_y),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_data), .out_tag(b_tag),
    .out_last(b_last), .sat_flag(b_sat),
    .vec_count(b_cnt)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] sum;
    logic        sat;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic a_beat(input string name,
                        input logic [15:0] d,
                        input logic [1:0] t,
                        input logic l,
                        input logic s);
    chk({name, " valid"}, {31'd0, a_out_valid}, 32'd1);
    chk({name, " data"}, {16'd0, a_data}, {16'd0, d});
    chk({name, " tag"}, {30'd0, a_tag}, {30'd0, t});
    chk({name, " last"}, {31'd0, a_last}, {31'd0, l});
    chk({name, " sat"}, {31'd0, a_sat}, {31'd0, s});
  endtask

  task automatic a_idle(input string name);
    chk({name, " in_ready"}, {31'd0, a_in_ready}, 32'd1);
    chk({name, " out_valid"}, {31'd0, a_out_valid}, 32'd0);
    chk({name, " count"}, {16'd0, a_cnt}, exp_cnt);
  endtask

  // called at a negedge with the instance idle
  task automatic run_vec(input vec_t v);
    a_in_valid = 1'b1;
    a_x = v.x;
    a_y = v.y;
    chk("accept in_ready", {31'd0, a_in_ready}, 32'd1);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_beat("cosh", v.x, 2'b00, 1'b0, 1'b0);
    chk("busy in_ready", {31'd0, a_in_ready}, 32'd0);
    @(negedge clk);
    a_beat("sinh", v.y, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    a_beat("exp", v.sum, 2'b10, 1'b1, v.sat);
    @(negedge clk);
    exp_cnt++;
    a_idle("post");
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'h4000, 16'h2000, 16'h6000, 1'b0};
    tbl[1] = '{16'h7000, 16'h2000, 16'h7FFF, 1'b1};
    tbl[2] = '{16'h9000, 16'h9000, 16'h8000, 1'b1};
    tbl[3] = '{16'hF000, 16'h0800, 16'hF800, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1};
    tbl[5] = '{16'h8000, 16'hFFFF, 16'h8000, 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    a_idle("reset");
    chk("reset data", {16'd0, a_data}, 32'd0);
    chk("reset tag", {30'd0, a_tag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_vec(tbl[i]);

    // backpressure while in SINH
    a_in_valid = 1'b1;
    a_x = 16'h4000;
    a_y = 16'h2000;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_beat("bp cosh", 16'h4000, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    a_out_ready = 1'b0;
    a_beat("bp sinh", 16'h2000, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = i[0];
      a_x = 16'h1234 + 16'(i);
      a_y = 16'h0F0F;
      @(negedge clk);
      a_beat("bp stall", 16'h2000, 2'b01, 1'b0, 1'b0);
      chk("bp in_ready", {31'd0, a_in_ready}, 32'd0);
    end
    a_out_ready = 1'b1;
    a_in_valid = 1'b0;
    @(negedge clk);
    a_beat("bp exp", 16'h6000, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    exp_cnt++;
    a_idle("bp post");

    // asynchronous reset in COSH
    a_in_valid = 1'b1;
    a_x = 16'h1111;
    a_y = 16'h2222;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_beat("rst cosh", 16'h1111, 2'b00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    a_idle("rst mid");
    chk("rst data", {16'd0, a_data}, 32'd0);
    chk("rst tag", {30'd0, a_tag}, 32'd0);
    chk("rst last", {31'd0, a_last}, 32'd0);
    chk("rst sat", {31'd0, a_sat}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    a_idle("rst released");
    run_vec(tbl[1]);

    // no exp beat, back-to-back vectors
    b_in_valid = 1'b1;
    b_x = 16'h1000;
    b_y = 16'h0100;
    @(negedge clk);
    chk("b c1 data", {16'd0, b_data}, 32'h1000);
    chk("b c1 tag", {30'd0, b_tag}, 32'd0);
    chk("b c1 last", {31'd0, b_last}, 32'd0);
    b_x = 16'h2000;
    b_y = 16'h0200;
    @(negedge clk);
    chk("b s1 data", {16'd0, b_data}, 32'h0100);
    chk("b s1 tag", {30'd0, b_tag}, 32'd1);
    chk("b s1 last", {31'd0, b_last}, 32'd1);
    chk("b s1 sat", {31'd0, b_sat}, 32'd0);
    chk("b s1 in_ready", {31'd0, b_in_ready}, 32'd0);
    @(negedge clk);
    chk("b idle in_ready", {31'd0, b_in_ready}, 32'd1);
    chk("b idle valid", {31'd0, b_out_valid}, 32'd0);
    chk("b count1", {16'd0, b_cnt}, 32'd1);
    @(negedge clk);
    chk("b c2 data", {16'd0, b_data}, 32'h2000);
    chk("b c2 tag", {30'd0, b_tag}, 32'd0);
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b s2 data", {16'd0, b_data}, 32'h0200);
    chk("b s2 tag", {30'd0, b_tag}, 32'd1);
    chk("b s2 last", {31'd0, b_last}, 32'd1);
    @(negedge clk);
    chk("b count2", {16'd0, b_cnt}, 32'd2);
    chk("b end valid", {31'd0, b_out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hyper_result_stage.md
# hyper_result_stage

Result serializer directly downstream of the stage-4 rotation unit. It captures the final X/Y pair (cosh/sinh of the input angle) with a valid/ready handshake and forms the saturated sum X+Y (exp). It then streams the results as tagged beats on a single result bus toward the system interface. It also counts completed vectors for debug and throughput checks.

## Interface
- DWIDTH, default IDWIDTH (from hyperCord_pkg): datapath width, two's complement, same fixed-point format as stage-4 outputs.
- EXP_EN, default 1: 1 emits the exp beat; 0 emits only cosh and sinh.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  Xin/Yin valid.
- in_ready  output  1  stage can accept a vector.
- Xin  input  DWIDTH  stage-4 Xout (cosh).
- Yin  input  DWIDTH  stage-4 Yout (sinh).
- out_valid  output  1  out_data/out_tag/out_last/sat_flag valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DWIDTH  result value.
- out_tag  output  2  00 cosh, 01 sinh, 10 exp; 11 never driven.
- out_last  output  1  final beat of the vector.
- sat_flag  output  1  exp beat was saturated; 0 on the other beats.
- vec_count  output  16  completed vectors, wraps 0xFFFF to 0x0000.

## Operation
- The FSM has four states: IDLE, COSH, SINH and EXP. Reset state is IDLE.
- in_ready = (state == IDLE). out_valid = (state != IDLE). Both are decoded from registered state only, with no combinational in-to-out paths.
- IDLE: when in_valid && in_ready, the block registers Xin into x_r and Yin into y_r. It also registers sum_r = sat(Xin + Yin) and ovf_r, then moves to COSH. If in_valid is low, it stays in IDLE.
- COSH: out_data = x_r, tag 00, out_last = 0. On out_ready the FSM moves to SINH.
- SINH: out_data = y_r, tag 01, out_last = !EXP_EN. On out_ready the FSM moves to EXP if EXP_EN, otherwise to IDLE.
- EXP: out_data = sum_r, tag 10, out_last = 1, sat_flag = ovf_r. On out_ready the FSM moves to IDLE.
- The sum is computed at DWIDTH+1 bits, signed. Overflow is detected when the top two bits of the sum differ.
  - Positive overflow saturates to 0 followed by all 1s (0x7FFF at 16 bits).
  - Negative overflow saturates to 1 followed by all 0s (0x8000).
  - Otherwise sum_r is the low DWIDTH bits of the sum.
- vec_count increments by 1 on the out_last handshake (out_valid && out_ready && out_last).
- While out_ready is low, out_data, out_tag, out_last and sat_flag hold stable. Input changes are ignored because in_ready = 0.
- Xin/Yin changing while in_ready = 0 has no effect.
- If rst_n is asserted mid-vector, the beats in flight are dropped, state returns to IDLE and all registers clear. No partial beat is emitted after reset releases.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, out_tag 00, out_last 0, sat_flag 0, vec_count 0, and x_r/y_r/sum_r/ovf_r at 0.
- Latency: a vector accepted at edge N presents the cosh beat with out_valid = 1 in the cycle after edge N.
- With out_ready held high:
  - EXP_EN = 1: beats appear on three consecutive cycles, then one IDLE cycle. Peak throughput is one vector per 4 cycles.
  - EXP_EN = 0: one vector per 3 cycles.
- in_ready is low from the accept edge until the edge that completes the out_last handshake. The earliest next accept is the following edge.
- Outputs are registered or decoded from state. out_ready affects only next-state logic.

## Test plan
- **Basic vector, DWIDTH = 16, EXP_EN = 1, out_ready = 1.**
  - Stimulus: Xin = 0x4000, Yin = 0x2000.
  - Required response: beats (0x4000, 00, last 0), (0x2000, 01, last 0), (0x6000, 10, last 1, sat 0) on three consecutive cycles. vec_count goes to 1 and in_ready returns high.
- **Positive saturation.**
  - Stimulus: Xin = 0x7000, Yin = 0x2000.
  - Required response: exp beat 0x7FFF with sat_flag = 1.
- **Negative saturation.**
  - Stimulus: Xin = 0x9000, Yin = 0x9000.
  - Required response: exp beat 0x8000 with sat_flag = 1.
  - Follow-up: Xin = 0xF000, Yin = 0x0800 gives 0xF800 with sat_flag = 0.
- **Backpressure.**
  - Stimulus: hold out_ready = 0 for 5 cycles while in SINH, then raise it. Toggle in_valid/Xin during the stall.
  - Required response: out_data = 0x2000 and tag 01 stay stable, in_ready stays 0, the new input is not captured, and EXP follows on the next cycle.
- **EXP_EN = 0, back-to-back in_valid = 1 with vectors (0x1000, 0x0100) and (0x2000, 0x0200).**
  - Required response: only tags 00 and 01 appear, with out_last on the sinh beat. Vector 2 is accepted on the edge after vector 1's last handshake. vec_count reads 1 then 2.
- **Reset mid-vector.**
  - Stimulus: pull rst_n low asynchronously while in COSH.
  - Required response: out_valid drops immediately, all outputs return to reset values, and vec_count reads 0.
  - Follow-up: after release, a fresh vector streams normally.
